// File: rtl/ts_uart_pkg.sv
// Shared types and helpers for the timestamp UART framer.
// Build option: define TS_UART_FRAMER_CKSUM_EN to append an XOR checksum byte to every frame.
package ts_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        DATA  = 2'd2,
        CKSUM = 2'd3
    } state_e;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    // Number of bytes on the wire for one record of ts_w bits.
    function automatic int frame_len(input int ts_w);
`ifdef TS_UART_FRAMER_CKSUM_EN
        return (ts_w / 8) + 2;
`else
        return (ts_w / 8) + 1;
`endif
    endfunction

    // One step of the running XOR checksum over the timestamp bytes.
    function automatic logic [7:0] cksum_step(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/ts_fifo.sv
// Synchronous record FIFO: push, pop, full, empty and level, no write-to-read bypass.
// A push while full or a pop while empty is ignored.
module ts_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             wr_data,
    input  logic                     pop,
    output logic [W-1:0]             rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [LW-1:0] level_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    // Qualify requests against the registered occupancy.
    always_comb begin
        full      = (level_r == LW'(DEPTH));
        empty     = (level_r == {LW{1'b0}});
        push_ok_s = push & ~full;
        pop_ok_s  = pop & ~empty;
        rd_data   = mem_r[rd_ptr_r];
        level     = level_r;
    end

    // Storage array; contents need no reset because level gates every read.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave the level unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/ts_uart_framer.sv
// Buffers non-stallable 64-bit timestamps and streams each one to uart_tx as
// SYNC_BYTE, timestamp bytes MSB first and, optionally, an XOR checksum byte.
// Build option: TS_UART_FRAMER_CKSUM_EN enables the checksum byte and CKSUM state.
module ts_uart_framer
    import ts_uart_pkg::*;
#(
    parameter int         TS_W      = 64,
    parameter int         DEPTH     = 4,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
    parameter int         DROP_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ts_valid,
    input  logic [TS_W-1:0]          ts_data,
    input  logic                     tx_ready,
    output logic                     tx_valid,
    output logic [7:0]               tx_data,
    output logic [DROP_W-1:0]        drop_count,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int NB = TS_W / 8;
    localparam int IW = $clog2(NB + 1);

    state_e             state_r;
    logic [TS_W-1:0]    shift_r;
    logic [IW-1:0]      idx_r;
    logic               tx_valid_r;
    logic [7:0]         tx_data_r;
    logic [DROP_W-1:0]  drop_r;
`ifdef TS_UART_FRAMER_CKSUM_EN
    logic [7:0]         cksum_r;
`endif

    logic               full_s;
    logic               empty_s;
    logic               push_s;
    logic               pop_s;
    logic               accept_s;
    logic               last_byte_s;
    logic [TS_W-1:0]    fifo_data_s;
    logic [TS_W-1:0]    shift_next_s;

    // Handshake decode; the full decision uses the registered level so a pop cannot rescue a push.
    always_comb begin
        push_s       = ts_valid & ~full_s;
        pop_s        = (state_r == IDLE) & ~empty_s;
        accept_s     = tx_valid_r & tx_ready;
        last_byte_s  = (idx_r == IW'(NB - 1));
        shift_next_s = shift_r << 8;
    end

    ts_fifo #(
        .W     (TS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_s),
        .wr_data (ts_data),
        .pop     (pop_s),
        .rd_data (fifo_data_s),
        .full    (full_s),
        .empty   (empty_s),
        .level   (fifo_level)
    );

    // Frame sequencer; tx_valid/tx_data are registered and only change on acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            shift_r    <= {TS_W{1'b0}};
            idx_r      <= {IW{1'b0}};
            tx_valid_r <= 1'b0;
            tx_data_r  <= 8'h00;
`ifdef TS_UART_FRAMER_CKSUM_EN
            cksum_r    <= 8'h00;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (!empty_s) begin
                        shift_r    <= fifo_data_s;
                        idx_r      <= {IW{1'b0}};
`ifdef TS_UART_FRAMER_CKSUM_EN
                        cksum_r    <= 8'h00;
`endif
                        state_r    <= SYNC;
                        tx_valid_r <= 1'b1;
                        tx_data_r  <= SYNC_BYTE;
                    end
                end
                SYNC: begin
                    if (accept_s) begin
                        state_r   <= DATA;
                        tx_data_r <= shift_r[TS_W-1 -: 8];
                    end
                end
                DATA: begin
                    if (accept_s) begin
                        shift_r <= shift_next_s;
                        idx_r   <= idx_r + IW'(1);
`ifdef TS_UART_FRAMER_CKSUM_EN
                        cksum_r <= cksum_step(cksum_r, tx_data_r);
`endif
                        if (last_byte_s) begin
`ifdef TS_UART_FRAMER_CKSUM_EN
                            state_r   <= CKSUM;
                            tx_data_r <= cksum_step(cksum_r, tx_data_r);
`else
                            state_r    <= IDLE;
                            tx_valid_r <= 1'b0;
                            tx_data_r  <= 8'h00;
`endif
                        end else begin
                            tx_data_r <= shift_next_s[TS_W-1 -: 8];
                        end
                    end
                end
`ifdef TS_UART_FRAMER_CKSUM_EN
                CKSUM: begin
                    if (accept_s) begin
                        state_r    <= IDLE;
                        tx_valid_r <= 1'b0;
                        tx_data_r  <= 8'h00;
                    end
                end
`endif
                default: begin
                    state_r    <= IDLE;
                    tx_valid_r <= 1'b0;
                    tx_data_r  <= 8'h00;
                end
            endcase
        end
    end

    // Saturating count of records dropped because the FIFO was full.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_r <= {DROP_W{1'b0}};
        end else if (ts_valid && full_s && (drop_r != {DROP_W{1'b1}})) begin
            drop_r <= drop_r + DROP_W'(1);
        end
    end

    assign tx_valid   = tx_valid_r;
    assign tx_data    = tx_data_r;
    assign drop_count = drop_r;

endmodule

// File: tb/tb_ts_uart_framer.sv
// Scoreboard bench for ts_uart_framer: expected frame bytes are queued as
// records are driven and compared as uart_tx would accept them.
module tb_ts_uart_framer;

`ifdef TS_UART_FRAMER_CKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        ts_valid;
    logic [63:0] ts_data;
    logic        tx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic [15:0] drop_count;
    logic [2:0]  fifo_level;

    ts_uart_framer dut (
        .clk        (clk),
        .rst        (rst),
        .ts_valid   (ts_valid),
        .ts_data    (ts_data),
        .tx_ready   (tx_ready),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .drop_count (drop_count),
        .fifo_level (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Entry: [9] last byte of frame, [8] first byte of frame, [7:0] byte value.
    logic [9:0] exp_q [$];
    int  n_checks = 0;
    int  n_pass   = 0;
    int  cyc      = 0;
    int  last_end = 0;
    bit  have_end = 1'b0;
    bit  gap_en   = 1'b0;
    int  accept_cnt = 0;
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic       prev_rst   = 1'b1;
    logic [7:0] prev_data  = 8'h00;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic expect_frame(input logic [63:0] d);
        logic [7:0] b;
        logic [7:0] x;
        x = 8'h00;
        exp_q.push_back({2'b01, 8'hA5});
        for (int i = 0; i < 8; i++) begin
            b = d[63-8*i -: 8];
            x = x ^ b;
            exp_q.push_back({((i == 7) && !CK), 1'b0, b});
        end
        if (CK) exp_q.push_back({2'b10, x});
    endtask

    task automatic push_ts(input logic [63:0] d);
        @(posedge clk); #1;
        ts_valid = 1'b1;
        ts_data  = d;
        expect_frame(d);
        @(posedge clk); #1;
        ts_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        check_eq("idle_after_frame", 64'(tx_valid), 64'd0);
    endtask

    // Scoreboard monitor: bytes are taken where tx_valid & tx_ready hold ahead of the edge.
    always @(negedge clk) begin
        logic [9:0] e;
        cyc++;
        if (!rst && tx_valid && tx_ready) begin
            accept_cnt++;
            if (exp_q.size() == 0) begin
                check_eq("unexpected_byte_queue", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                check_eq("byte", 64'(tx_data), 64'(e[7:0]));
                if (e[8] && gap_en && have_end)
                    check_eq("frame_gap", 64'(cyc - last_end - 1), 64'd1);
                if (e[9]) begin
                    last_end = cyc;
                    have_end = 1'b1;
                end
            end
        end
        if (!rst && !prev_rst && prev_valid && !prev_ready) begin
            check_eq("hold_valid", 64'(tx_valid), 64'd1);
            check_eq("hold_data", 64'(tx_data), 64'(prev_data));
        end
        prev_valid = tx_valid;
        prev_ready = tx_ready;
        prev_data  = tx_data;
        prev_rst   = rst;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int target;
        logic [63:0] recs [6];
        rst      = 1'b1;
        ts_valid = 1'b0;
        ts_data  = 64'd0;
        tx_ready = 1'b0;
        recs[0] = 64'h1111_2222_3333_4444;
        recs[1] = 64'h5555_6666_7777_8888;
        recs[2] = 64'h99AA_BBCC_DDEE_FF00;
        recs[3] = 64'hDEAD_BEEF_0BAD_F00D;
        recs[4] = 64'h0000_0000_0000_0001;
        recs[5] = 64'hFFFF_FFFF_FFFF_FFFF;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rst_tx_valid", 64'(tx_valid), 64'd0);
        check_eq("rst_tx_data", 64'(tx_data), 64'd0);
        check_eq("rst_level", 64'(fifo_level), 64'd0);
        check_eq("rst_drop", 64'(drop_count), 64'd0);

        // Single record, ready held high, latency of two cycles.
        tx_ready = 1'b1;
        push_ts(64'h0000_0000_0000_007B);
        @(negedge clk);
        check_eq("latency_e0", 64'(tx_valid), 64'd0);
        @(negedge clk);
        check_eq("latency_e1", 64'(tx_valid), 64'd1);
        wait_drain(50);

        // Pseudo-random back-pressure.
        push_ts(64'h0123_4567_89AB_CDEF);
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk); #1;
            tx_ready = 1'($urandom_range(0, 1));
            n++;
        end
        tx_ready = 1'b1;
        wait_drain(50);

        // Six back-to-back records with uart_tx stalled: one in flight, four queued, one dropped.
        tx_ready = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            ts_valid = 1'b1;
            ts_data  = recs[i];
            if (i < 5) expect_frame(recs[i]);
            @(posedge clk); #1;
        end
        ts_valid = 1'b0;
        @(negedge clk);
        check_eq("full_level", 64'(fifo_level), 64'd4);
        check_eq("full_drop", 64'(drop_count), 64'd1);
        have_end = 1'b0;
        gap_en   = 1'b1;
        tx_ready = 1'b1;
        wait_drain(300);
        gap_en   = 1'b0;

        // Push coinciding with the IDLE pop while two records are queued.
        tx_ready = 1'b0;
        push_ts(recs[0]);
        push_ts(recs[1]);
        push_ts(recs[2]);
        @(negedge clk);
        check_eq("pp_level_before", 64'(fifo_level), 64'd2);
        tx_ready = 1'b1;
        n = 0;
        @(negedge clk);
        while (tx_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("pp_found_idle", 64'(tx_valid), 64'd0);
        ts_valid = 1'b1;
        ts_data  = recs[3];
        expect_frame(recs[3]);
        @(posedge clk); #1;
        ts_valid = 1'b0;
        @(negedge clk);
        check_eq("pp_level_after", 64'(fifo_level), 64'd2);
        check_eq("pp_drop", 64'(drop_count), 64'd1);
        wait_drain(200);

        // Reset in the middle of DATA with two records queued.
        tx_ready = 1'b0;
        push_ts(recs[4]);
        push_ts(recs[5]);
        push_ts(recs[0]);
        target = accept_cnt + 4;
        tx_ready = 1'b1;
        n = 0;
        while (accept_cnt < target && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("pre_rst_accepts", 64'(accept_cnt), 64'(target));
        check_eq("pre_rst_level", 64'(fifo_level), 64'd2);
        @(posedge clk); #1;
        tx_ready = 1'b0;
        rst      = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_tx_valid", 64'(tx_valid), 64'd0);
        check_eq("mid_rst_level", 64'(fifo_level), 64'd0);
        check_eq("mid_rst_drop", 64'(drop_count), 64'd0);
        tx_ready = 1'b1;
        push_ts(64'h0000_0000_0000_007B);
        wait_drain(50);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
